cpu_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the 8-bit / 16-bit-instruction CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the PC, IR, register-file, ALU and memory-port control strobes. It sits between the instruction/data memory handshake and the existing datapath inside `cpu`, replacing hard-wired single-cycle control.

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/cpu_ctrl_decode.sv | 25 ++
 rtl/cpu_ctrl_seq.sv | 128 ++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared states, opcodes, pc_src and ALU encodings for the CPU control sequencer.
package cpu_ctrl_pkg;
   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_SW   = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_ILL0 = 4'hD;
   localparam logic [3:0] OP_ILL1 = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;
   localparam logic [2:0] ALU_SHL = 3'd7;
endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational opcode classifier; NOP is the opcode with no class set.
module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_alu,
   output logic       is_imm,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jump,
   output logic       is_halt,
   output logic       is_illegal
);
   always_comb begin
      is_alu     = !opcode[3] && (opcode != OP_NOP);
      is_imm     = opcode == OP_ADDI;
      is_load    = opcode == OP_LW;
      is_store   = opcode == OP_SW;
      is_branch  = opcode == OP_BEQ;
      is_jump    = opcode == OP_JMP;
      is_halt    = opcode == OP_HALT;
      is_illegal = (opcode == OP_ILL0) || (opcode == OP_ILL1);
   end
endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle fetch/decode/exec/mem/wb control sequencer.
// Optional memory-ack watchdog enabled by defining CTRL_MEM_TIMEOUT_EN.
module cpu_ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [15:0] Instruction,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [2:0]  alu_op,
   output logic        alu_src,
   output logic        reg_write,
   output logic        wb_sel,
   output logic        retired,
   output logic        halted,
   output logic        fault
);
   state_t state, nxt;
   logic   set_fault;
   logic   is_alu, is_imm, is_load, is_store, is_branch, is_jump, is_halt, is_illegal;
   logic   unused_bits;

   cpu_ctrl_decode u_dec (
      .opcode    (Instruction[15:12]),
      .is_alu    (is_alu),
      .is_imm    (is_imm),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .is_jump   (is_jump),
      .is_halt   (is_halt),
      .is_illegal(is_illegal)
   );

   assign unused_bits = ^{Instruction[11:0], TIMEOUT_CYCLES != 0};
   assign halted      = state == S_HALT;

`ifdef CTRL_MEM_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       waiting, expired;
   assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
   assign expired = waiting && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) wait_cnt <= '0;
      else wait_cnt <= waiting ? wait_cnt + 8'd1 : '0;
`else
   logic expired;
   assign expired = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state <= S_BOOT;
         fault <= 1'b0;
      end else begin
         state <= nxt;
         fault <= fault | set_fault;
      end

   always_comb begin
      nxt       = state;
      set_fault = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_INC;
      alu_op    = 3'd0;
      alu_src   = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      retired   = 1'b0;
      case (state)
         S_BOOT: nxt = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ack;
            pc_write = mem_ack;
            nxt      = mem_ack ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            pc_write  = is_jump;
            pc_src    = is_jump ? PC_JMP : PC_INC;
            set_fault = is_illegal;
            retired   = is_jump || !(is_alu || is_imm || is_load || is_store || is_branch || is_halt || is_illegal);
            nxt       = (is_halt || is_illegal) ? S_HALT :
                        retired ? S_FETCH : S_EXEC;
         end
         S_EXEC: begin
            alu_op   = is_alu ? Instruction[14:12] : is_branch ? ALU_SUB : ALU_ADD;
            alu_src  = is_imm || is_load || is_store;
            pc_write = is_branch && zero;
            pc_src   = is_branch ? PC_BR : PC_INC;
            retired  = is_branch;
            nxt      = is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = is_store;
            retired = is_store && mem_ack;
            nxt     = !mem_ack ? S_MEM : is_store ? S_FETCH : S_WB;
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = is_load;
            retired   = 1'b1;
            nxt       = S_FETCH;
         end
         default: nxt = S_HALT;
      endcase
      // A watchdog expiry wins over whatever the wait state wanted to do.
      if (expired) begin
         nxt       = S_HALT;
         set_fault = 1'b1;
      end
   end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: table-driven per-cycle checks of cpu_ctrl_seq strobes plus reset/timeout sequences.
module tb_cpu_ctrl_seq;
   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [15:0] Instruction = 16'h0000;
   logic        zero = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_req, mem_we, mem_sel, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic [2:0]  alu_op;
   logic        alu_src, reg_write, wb_sel, retired, halted, fault;
   logic [15:0] act;
   int          tests = 0;
   int          failed = 0;

   localparam logic [15:0] NONE = 16'h0000;
   localparam logic [15:0] MREQ = 16'h8000;
   localparam logic [15:0] MWE  = 16'h4000;
   localparam logic [15:0] MSEL = 16'h2000;
   localparam logic [15:0] IRW  = 16'h1000;
   localparam logic [15:0] PCW  = 16'h0800;
   localparam logic [15:0] PCS1 = 16'h0200;
   localparam logic [15:0] PCS2 = 16'h0400;
   localparam logic [15:0] ASRC = 16'h0020;
   localparam logic [15:0] RW   = 16'h0010;
   localparam logic [15:0] WBS  = 16'h0008;
   localparam logic [15:0] RET  = 16'h0004;
   localparam logic [15:0] HLT  = 16'h0002;
   localparam logic [15:0] FLT  = 16'h0001;
   localparam logic [15:0] FET  = MREQ | IRW | PCW;

   typedef struct {
      logic [15:0] instr;
      logic        zero;
      logic        ack;
      logic [15:0] exp;
   } vec_t;

   function automatic logic [15:0] aop(input int n);
      return 16'(n) << 6;
   endfunction

   cpu_ctrl_seq #(.TIMEOUT_CYCLES(8)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .Instruction(Instruction), .zero(zero),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
      .alu_src(alu_src), .reg_write(reg_write), .wb_sel(wb_sel), .retired(retired),
      .halted(halted), .fault(fault)
   );

   assign act = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, alu_op,
                 alu_src, reg_write, wb_sel, retired, halted, fault};

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input string name, input logic [15:0] instr, input logic z,
                       input logic ack, input logic [15:0] exp);
      @(negedge CLK);
      Instruction = instr;
      zero = z;
      mem_ack = ack;
      #1 check(name, exp);
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RESET_N = 1'b1;
      #1 check("boot", NONE);
   endtask

   task automatic pull_reset(input string name);
      RESET_N = 1'b0;
      #1 check(name, NONE);
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{16'h1123, 1'b0, 1'b1, FET},
         '{16'h1123, 1'b0, 1'b0, NONE},
         '{16'h1123, 1'b0, 1'b0, aop(1)},
         '{16'h1123, 1'b0, 1'b0, RW | RET},
         '{16'h9104, 1'b0, 1'b1, FET},
         '{16'h9104, 1'b0, 1'b0, NONE},
         '{16'h9104, 1'b0, 1'b0, aop(1) | ASRC},
         '{16'h9104, 1'b0, 1'b0, MREQ | MSEL},
         '{16'h9104, 1'b0, 1'b0, MREQ | MSEL},
         '{16'h9104, 1'b0, 1'b0, MREQ | MSEL},
         '{16'h9104, 1'b0, 1'b1, MREQ | MSEL},
         '{16'h9104, 1'b0, 1'b0, RW | WBS | RET},
         '{16'hB0FE, 1'b1, 1'b1, FET},
         '{16'hB0FE, 1'b1, 1'b0, NONE},
         '{16'hB0FE, 1'b1, 1'b0, aop(2) | PCW | PCS1 | RET},
         '{16'hB0FE, 1'b0, 1'b1, FET},
         '{16'hB0FE, 1'b0, 1'b0, NONE},
         '{16'hB0FE, 1'b0, 1'b0, aop(2) | PCS1 | RET},
         '{16'h8105, 1'b0, 1'b1, FET},
         '{16'h8105, 1'b0, 1'b0, NONE},
         '{16'h8105, 1'b0, 1'b0, aop(1) | ASRC},
         '{16'h8105, 1'b0, 1'b0, RW | RET},
         '{16'hA104, 1'b0, 1'b0, MREQ},
         '{16'hA104, 1'b0, 1'b1, FET},
         '{16'hA104, 1'b0, 1'b0, NONE},
         '{16'hA104, 1'b0, 1'b0, aop(1) | ASRC},
         '{16'hA104, 1'b0, 1'b0, MREQ | MSEL | MWE},
         '{16'hA104, 1'b0, 1'b1, MREQ | MSEL | MWE | RET},
         '{16'hC010, 1'b0, 1'b1, FET},
         '{16'hC010, 1'b0, 1'b0, PCW | PCS2 | RET},
         '{16'h0000, 1'b0, 1'b1, FET},
         '{16'h0000, 1'b0, 1'b1, RET},
         '{16'h7000, 1'b0, 1'b1, FET},
         '{16'h7000, 1'b0, 1'b1, NONE},
         '{16'h7000, 1'b0, 1'b1, aop(7)},
         '{16'h7000, 1'b0, 1'b1, RW | RET},
         '{16'hF000, 1'b0, 1'b1, FET},
         '{16'hF000, 1'b0, 1'b1, NONE},
         '{16'hF000, 1'b0, 1'b1, HLT},
         '{16'hF000, 1'b0, 1'b1, HLT}
      };
      repeat (2) @(negedge CLK);
      #1 check("reset", NONE);
      release_reset();
      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].zero, vecs[i].ack, vecs[i].exp);

      pull_reset("halt_clear");
      release_reset();
      step("ill_fetch", 16'hD000, 1'b0, 1'b1, FET);
      step("ill_decode", 16'hD000, 1'b0, 1'b1, NONE);
      step("ill_halt0", 16'hD000, 1'b0, 1'b1, HLT | FLT);
      step("ill_halt1", 16'hD000, 1'b0, 1'b0, HLT | FLT);
      pull_reset("fault_clear");

      release_reset();
      step("sw_fetch", 16'hA104, 1'b0, 1'b1, FET);
      step("sw_decode", 16'hA104, 1'b0, 1'b0, NONE);
      step("sw_exec", 16'hA104, 1'b0, 1'b0, aop(1) | ASRC);
      step("sw_mem", 16'hA104, 1'b0, 1'b0, MREQ | MSEL | MWE);
      pull_reset("sw_reset_drop");
      release_reset();
      step("sw_refetch", 16'hA104, 1'b0, 1'b0, MREQ);

      pull_reset("wd_reset");
      release_reset();
`ifdef CTRL_MEM_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step($sformatf("wd_wait%0d", i), 16'h1123, 1'b0, 1'b0, MREQ);
      step("wd_fault0", 16'h1123, 1'b0, 1'b0, HLT | FLT);
      step("wd_fault1", 16'h1123, 1'b0, 1'b0, HLT | FLT);
`else
      for (int i = 0; i < 100; i++) step($sformatf("wait%0d", i), 16'h1123, 1'b0, 1'b0, MREQ);
      step("wait_ack", 16'h1123, 1'b0, 1'b1, FET);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
